mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter that sits on the single-cycle core's data-memory bus as a responder beside `Data_Memory`, sharing the same `we`/`a`/`wd`/`rd` signalling. Core stores to its register window push bytes into a small FIFO. A shift engine serialises them onto `tx` as 8N1 frames at a programmable bit rate. The top level muxes `rd` between `Data_Memory` and this block on address hit.

## Interface
- `BASE_ADDR`, 32'h0000_0400: register window base; window is 16 bytes, decoded on `a[31:4]`.
- `FIFO_DEPTH`, 4: TX FIFO entries, power of two, minimum 2.
- `DIV_RESET`, 16'd867: reset value of BAUDDIV (100 MHz / 115200).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `we`  in  1  store strobe from the core; effective only on window hit.
- `a`  in  32  byte address (the core's ALU result).
- `wd`  in  32  store data.
- `rd`  out  32  combinational read data; 0 when `a` misses the window.
- `tx`  out  1  serial line, idle high.

## Operation
- hit = (`a[31:4]` == `BASE_ADDR[31:4]`). Register select is `a[3:2]`; `a[1:0]` is ignored.
- Offset 0x0 TXDATA:
  - A write pushes `wd[7:0]`.
  - A read returns 0.
- Offset 0x4 STATUS reads {28'b0, ovf, busy, empty, full}:
  - bit0 full; bit1 empty; bit2 busy (state != IDLE); bit3 ovf (sticky).
  - A write with `wd[3]`=1 clears ovf; all other bits are read-only.
- Offset 0x8 BAUDDIV:
  - Read/write `wd[15:0]`; reads zero-extend.
  - Each bit lasts DIV+1 cycles; DIV=0 gives 1 cycle per bit.
- Offset 0xC is reserved: reads 0, writes are ignored.
- Push to a full FIFO:
  - If no pop happens in the same cycle, the byte is dropped and ovf is set.
  - If a pop happens in the same cycle, the push is accepted and the count is unchanged.
- FSM states IDLE, START, DATA, STOP; 16-bit baud counter; 3-bit bit index.
  - IDLE: if the FIFO is non-empty, pop into the shift register, go to START, load the baud counter.
  - START: `tx`=0 for DIV+1 cycles, then go to DATA with index 0.
  - DATA: `tx`=shift[0], LSB first. Shift at each bit end. After index 7 go to STOP.
  - STOP: `tx`=1 for DIV+1 cycles. At the end, pop and go straight to START if the FIFO is non-empty, otherwise go to IDLE. Back-to-back frames have no idle gap.
- A BAUDDIV write while busy takes effect at the next bit boundary (next counter reload).

## Timing
- Reset values:
  - `tx`=1, state IDLE, FIFO empty, ovf=0, BAUDDIV=`DIV_RESET`.
  - STATUS reads 0x0000_0002.
- `reset` low forces `tx` high immediately, mid-frame included, and discards FIFO contents.
- `rd` is purely combinational from `a` and current state, with no read latency, so the single-cycle core's loads complete the same cycle.
- Write accepted at edge N into an empty FIFO with IDLE engine:
  - pop at edge N+1; `tx` falls after edge N+1;
  - frame length 10×(DIV+1) cycles.
- STATUS reflects a push or pop from the cycle after the edge that performed it.

## Structure
- Package `mmio_uart_pkg` holds:
  - register offsets (TXDATA, STATUS, BAUDDIV);
  - STATUS bit positions;
  - FSM state enum;
  - frame length constant (10).
- Sub-module `tx_fifo` is a synchronous FIFO:
  - parameterised on width 8 and depth;
  - push, pop, full, empty, count;
  - simultaneous push and pop allowed when full.
- The top level of the block does decode, register file and shift FSM.

## Test plan
- Reset:
  - `tx`=1;
  - STATUS read = 0x0000_0002;
  - BAUDDIV read = 0x0000_0363.
- Single byte at DIV=3, write 0x55:
  - `tx` low for 4 cycles starting the cycle after the pop;
  - then 1,0,1,0,1,0,1,0 at 4 cycles each;
  - stop high for 4 cycles; 40 cycles total;
  - busy=1 throughout, then STATUS=0x2.
- Overflow at DIV=3, write 0x01..0x06 to TXDATA on six consecutive cycles:
  - 0x01..0x05 accepted, 0x06 dropped;
  - STATUS = 0xD (ovf, busy, full);
  - five frames back-to-back with no idle gap, 200 cycles, then IDLE.
- ovf clear:
  - STATUS write 0x0 leaves ovf=1;
  - STATUS write 0x8 clears it on the next cycle.
- Decode, with `we`=1, `a`=0x0000_0410 and `a`=0x0000_040C:
  - FIFO unchanged, `rd`=0 for both;
  - `a`=0x0000_0407 reads STATUS.
- Reset mid-DATA, asserted at bit 3 of a frame:
  - `tx`=1 immediately;
  - after release STATUS=0x2 and no residual frame is sent.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register map, STATUS layout, engine states and frame geometry.
package mmio_uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  function automatic logic [31:0] status_word(
    input logic ovf,
    input logic busy,
    input logic empty,
    input logic full
  );
    logic [31:0] s;
    s = '0;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    s[STAT_BUSY]  = busy;
    s[STAT_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous TX FIFO; a push into a full FIFO is taken only
// when a pop retires an entry on the same edge.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: bus decode, register file and 8N1
// shift engine fed from a small TX FIFO.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx
);

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0]  LAST_DATA = 3'(FRAME_BITS - 3);

  logic        hit;
  logic [1:0]  sel;
  logic        wr_data;
  logic        wr_status;
  logic        wr_div;

  logic [15:0] div;
  logic        ovf;

  logic        push;
  logic        pop;
  logic [7:0]  fifo_dout;
  logic        full;
  logic        empty;
  logic [CW-1:0] count;

  tx_state_e   state;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shift;
  logic        bit_end;
  logic        busy;
  logic [31:0] status;

  logic        unused_ok;

  assign hit = (a[31:4] == BASE_ADDR[31:4]);
  assign sel = a[3:2];

  always_comb begin
    wr_data   = 1'b0;
    wr_status = 1'b0;
    wr_div    = 1'b0;
    if (we && hit) begin
      unique case (1'b1)
        (sel == REG_TXDATA):  wr_data   = 1'b1;
        (sel == REG_STATUS):  wr_status = 1'b1;
        (sel == REG_BAUDDIV): wr_div    = 1'b1;
        (sel == REG_RSVD):    ;
      endcase
    end
  end

  assign push    = wr_data;
  assign bit_end = (cnt == '0);
  assign busy    = (state != IDLE);
  // Engine takes the next byte when idle or at the last stop-bit cycle.
  assign pop     = !empty &&
                   ((state == IDLE) || ((state == STOP) && bit_end));

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (wd[7:0]),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= DIV_RESET;
      ovf <= 1'b0;
    end else begin
      if (wr_div) begin
        div <= wd[15:0];
      end
      if (push && full && !pop) begin
        ovf <= 1'b1;
      end else if (wr_status && wd[STAT_OVF]) begin
        ovf <= 1'b0;
      end
    end
  end

  assign status = status_word(ovf, busy, empty, full);

  always_comb begin
    rd = '0;
    if (hit) begin
      unique case (sel)
        REG_STATUS:  rd = status;
        REG_BAUDDIV: rd = {16'b0, div};
        REG_TXDATA:  rd = '0;
        REG_RSVD:    rd = '0;
      endcase
    end
  end

  // tx is registered; each transition sets the level of the next bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            shift <= fifo_dout;
            cnt   <= div;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= div;
            idx   <= '0;
            state <= DATA;
            tx    <= shift[0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= div;
            if (idx == LAST_DATA) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              shift <= {1'b0, shift[7:1]};
              tx    <= shift[1];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift <= fifo_dout;
              cnt   <= div;
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign unused_ok = ^{a[1:0], wd[31:16], count};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench: a timing model predicts accepted bytes and frame
// start cycles; a line receiver decodes tx and checks against them.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE    = 32'h0000_0400;
  localparam int          DEPTH   = 4;
  localparam logic [15:0] DIV_RST = 16'd867;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        tx;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .DIV_RESET  (DIV_RST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .tx    (tx)
  );

  typedef struct {
    logic [7:0] data;
    int         start;
    int         div;
  } frame_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  frame_t      exp_q[$];
  logic [7:0]  m_q[$];
  int          m_frame_end = 0;
  int          m_div = int'(DIV_RST);
  bit          m_ovf = 1'b0;
  bit          mon_en = 1'b0;
  bit          mon_busy = 1'b0;
  logic [31:0] pre_rd;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model_status();
    logic busy;
    busy = (cyc < m_frame_end);
    return {28'b0, m_ovf, busy, (m_q.size() == 0), (m_q.size() == DEPTH)};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // One bus cycle; the model applies the same edge's pop then push.
  task automatic step(input bit w, input logic [31:0] addr,
                      input logic [31:0] data);
    int     e;
    bit     pop;
    frame_t f;
    we = w;
    a  = addr;
    wd = data;
    #1;
    pre_rd = rd;
    e = cyc + 1;
    pop = (m_q.size() > 0) && (e >= m_frame_end);
    if (pop) begin
      f.data = m_q.pop_front();
      f.start = e;
      f.div = m_div;
      exp_q.push_back(f);
      m_frame_end = e + 10 * (m_div + 1);
    end
    if (w && (addr[31:4] == BASE[31:4])) begin
      case (addr[3:2])
        2'd0: if (m_q.size() < DEPTH) m_q.push_back(data[7:0]);
              else m_ovf = 1'b1;
        2'd1: if (data[3]) m_ovf = 1'b0;
        2'd2: m_div = int'(data[15:0]);
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd_check(input logic [31:0] addr, input logic [31:0] exp,
                          input string name);
    we = 1'b0;
    a  = addr;
    #1;
    check(name, rd, exp);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || mon_busy || cyc < m_frame_end ||
            m_q.size() > 0) && n < 3000) begin
      step(1'b0, BASE + 32'h4, '0);
      rd_check(BASE + 32'h4, model_status(), {name, "_status"});
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL %s_drain: timeout, %0d frames pending want 0",
               name, exp_q.size());
    end
  endtask

  // Line receiver: samples every cycle of a frame at the negedge.
  initial begin
    frame_t     f;
    int         bl;
    int         k;
    logic [9:0] bits;
    bit         stable;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: start at cyc %0d, none expected",
                   cyc);
          k = 0;
          while (tx !== 1'b1 && k < 20000) begin
            @(negedge clk);
            k++;
          end
        end else begin
          f = exp_q.pop_front();
          bl = f.div + 1;
          check("frame_start", cyc, f.start);
          stable = 1'b1;
          bits = '0;
          for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < bl; j++) begin
              if (!(b == 0 && j == 0)) @(negedge clk);
              if (j == 0) bits[b] = tx;
              else if (tx !== bits[b]) stable = 1'b0;
            end
          end
          check("start_bit", 32'(bits[0]), 32'd0);
          check("data_byte", 32'(bits[8:1]), 32'(f.data));
          check("stop_bit", 32'(bits[9]), 32'd1);
          check("bit_stable", 32'(stable), 32'd1);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         p;
    int         hi;
    int         d;
    int         n;
    logic [7:0] fb;

    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    rd_check(BASE + 32'h4, 32'h0000_0002, "reset_status");
    rd_check(BASE + 32'h8, 32'h0000_0363, "reset_bauddiv");

    step(1'b1, 32'h0000_0410, 32'h0000_00AA);
    check("miss_rd", pre_rd, 32'h0);
    step(1'b1, 32'h0000_040C, 32'h0000_005A);
    check("rsvd_rd", pre_rd, 32'h0);
    rd_check(BASE + 32'h4, 32'h0000_0002, "decode_fifo_unchanged");
    rd_check(32'h0000_0407, 32'h0000_0002, "status_alias");
    rd_check(32'h0000_0410, 32'h0, "miss_read");

    step(1'b1, BASE + 32'h8, 32'h0000_0003);
    rd_check(BASE + 32'h8, 32'h3, "bauddiv_write");

    // Reset in the middle of data bit 3.
    fb = 8'hF7;
    step(1'b1, BASE, 32'(fb));
    p = cyc + 1;
    while (cyc < p + 17) step(1'b0, BASE + 32'h4, '0);
    check("pre_reset_bit3", 32'(tx), 32'(fb[3]));
    #1 reset = 1'b0;
    #1 check("reset_forces_tx", 32'(tx), 32'd1);
    m_q.delete();
    exp_q.delete();
    m_frame_end = 0;
    m_div = int'(DIV_RST);
    m_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    hi = 1;
    repeat (60) begin
      step(1'b0, BASE + 32'h4, '0);
      if (tx !== 1'b1) hi = 0;
    end
    check("no_residual_frame", 32'(hi), 32'd1);
    rd_check(BASE + 32'h4, 32'h0000_0002, "post_reset_status");

    mon_en = 1'b1;
    step(1'b1, BASE + 32'h8, 32'h0000_0003);
    step(1'b1, BASE, 32'h0000_0055);
    drain("single");
    rd_check(BASE + 32'h4, 32'h0000_0002, "single_done");

    for (int i = 1; i <= 6; i++) step(1'b1, BASE, 32'(i));
    rd_check(BASE + 32'h4, 32'h0000_000D, "ovf_status");
    step(1'b1, BASE + 32'h4, 32'h0);
    rd_check(BASE + 32'h4, model_status(), "ovf_write0");
    check("ovf_kept", 32'(rd[3]), 32'd1);
    step(1'b1, BASE + 32'h4, 32'h8);
    rd_check(BASE + 32'h4, model_status(), "ovf_write8");
    check("ovf_cleared", 32'(rd[3]), 32'd0);
    drain("overflow");

    // DIV=0 with a write every cycle exercises push+pop while full.
    step(1'b1, BASE + 32'h8, 32'hABCD_0000);
    rd_check(BASE + 32'h8, 32'h0, "bauddiv_zero");
    repeat (14) step(1'b1, BASE, $urandom);
    rd_check(BASE + 32'h4, model_status(), "fullpp_status");
    step(1'b1, BASE + 32'h4, 32'h8);
    drain("fullpp");

    repeat (6) begin
      d = $urandom_range(0, 4);
      step(1'b1, BASE + 32'h8, {16'($urandom), 16'(d)});
      rd_check(BASE + 32'h8, 32'(d), "bauddiv_rw");
      n = $urandom_range(3, 10);
      repeat (n) step(($urandom_range(0, 2) != 0), BASE, $urandom);
      rd_check(BASE + 32'h4, model_status(), "rand_status");
      step(1'b1, BASE + 32'h4, 32'h8);
      drain("rand");
    end
    rd_check(BASE + 32'h4, 32'h0000_0002, "final_status");

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
